gecko_load_writeback: RTL and testbench

- Memory-response stage of the Gecko core. It sits downstream of the execute stage, which issues `gecko_mem_operation_t` records alongside data-memory requests.
- It queues load metadata, pairs each in-order memory read response with its metadata, formats the value, and emits a `gecko_operation_t` writeback stream.
- It also emits a `gecko_forwarded_t` bypass for the decode/issue stage.
- Stores never enter this block.

---
 rtl/gecko_load_writeback_pkg.sv | 88 ++++++++
 rtl/gecko_mem_op_queue.sv | 72 +++++++
 rtl/gecko_load_writeback.sv | 78 +++++++
 tb/tb_gecko_load_writeback.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gecko_load_writeback_pkg.sv
// Shared Gecko types and helpers for the load writeback stage: memory-op metadata,
// writeback operation, forwarding record and load formatting.
package gecko_load_writeback_pkg;

    localparam int GECKO_LOAD_QUEUE_DEPTH = 4;

    // funct3 encodings of the load instructions
    localparam logic [2:0] GECKO_LS_B  = 3'b000;
    localparam logic [2:0] GECKO_LS_H  = 3'b001;
    localparam logic [2:0] GECKO_LS_W  = 3'b010;
    localparam logic [2:0] GECKO_LS_BU = 3'b100;
    localparam logic [2:0] GECKO_LS_HU = 3'b101;

    typedef logic [4:0] gecko_reg_address_t;
    typedef logic [3:0] gecko_reg_status_t;

    typedef struct packed {
        gecko_reg_address_t addr;
        gecko_reg_status_t  reg_status;
        logic               jump_flag;
        logic [2:0]         op;
        logic [1:0]         offset;
    } gecko_mem_operation_t;

    typedef struct packed {
        logic [31:0]        value;
        gecko_reg_address_t addr;
        logic               speculative;
        gecko_reg_status_t  reg_status;
        logic               jump_flag;
    } gecko_operation_t;

    typedef struct packed {
        logic               valid;
        logic [31:0]        value;
        gecko_reg_address_t addr;
        gecko_reg_status_t  reg_status;
    } gecko_forwarded_t;

    function automatic logic [31:0] gecko_get_load_result(
        input logic [31:0] word,
        input logic [1:0]  offset,
        input logic [2:0]  op
    );
        logic [31:0] shifted;
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        logic [31:0] result;
        shifted = word >> {offset, 3'b000};
        lane_b  = shifted[7:0];
        lane_h  = offset[1] ? word[31:16] : word[15:0];
        case (op)
            GECKO_LS_B:  result = {{24{lane_b[7]}}, lane_b};
            GECKO_LS_H:  result = {{16{lane_h[15]}}, lane_h};
            GECKO_LS_BU: result = {24'b0, lane_b};
            GECKO_LS_HU: result = {16'b0, lane_h};
            default:     result = word;
        endcase
        return result;
    endfunction

    function automatic gecko_operation_t gecko_get_load_operation(
        input gecko_mem_operation_t mem_op,
        input logic [31:0]          word
    );
        gecko_operation_t result;
        result             = '0;
        result.value       = gecko_get_load_result(word, mem_op.offset, mem_op.op);
        result.addr        = mem_op.addr;
        result.speculative = 1'b0;
        result.reg_status  = mem_op.reg_status;
        result.jump_flag   = mem_op.jump_flag;
        return result;
    endfunction

    function automatic gecko_forwarded_t gecko_construct_forward(
        input logic             valid,
        input gecko_operation_t operation
    );
        gecko_forwarded_t fwd;
        fwd.valid      = valid;
        fwd.value      = operation.value;
        fwd.addr       = operation.addr;
        fwd.reg_status = operation.reg_status;
        return fwd;
    endfunction

endpackage

// File: rtl/gecko_mem_op_queue.sv
// Circular FIFO of load metadata; push is refused while full, pop while empty.
module gecko_mem_op_queue
    import gecko_load_writeback_pkg::*;
#(
    parameter int DEPTH = GECKO_LOAD_QUEUE_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  gecko_mem_operation_t         push_data,
    input  logic                         pop,
    output gecko_mem_operation_t         head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    gecko_mem_operation_t mem_q [DEPTH];
    gecko_mem_operation_t mem_d [DEPTH];
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/gecko_load_writeback.sv
// Pairs in-order memory read responses with queued load metadata and emits a
// registered, formatted writeback operation plus a bypass for decode/issue.
module gecko_load_writeback
    import gecko_load_writeback_pkg::*;
#(
    parameter int DEPTH = GECKO_LOAD_QUEUE_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_op_valid,
    output logic                       mem_op_ready,
    input  gecko_mem_operation_t       mem_op_data,
    input  logic                       mem_resp_valid,
    output logic                       mem_resp_ready,
    input  logic [31:0]                mem_resp_data,
    output logic                       load_result_valid,
    input  logic                       load_result_ready,
    output gecko_operation_t           load_result_data,
    output gecko_forwarded_t           load_forward,
    output logic [$clog2(DEPTH+1)-1:0] outstanding_count
);

    // Handshakes: a transfer happens on a cycle where valid && ready are both high;
    // valid never waits on ready, and the result is held stable while valid && !ready.

    gecko_mem_operation_t q_head;
    logic                 q_full;
    logic                 q_empty;
    logic                 resp_fire;
    logic                 result_fire;
    logic                 result_valid_q, result_valid_d;
    gecko_operation_t     result_q, result_d;

    gecko_mem_op_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (mem_op_valid),
        .push_data (mem_op_data),
        .pop       (resp_fire),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (outstanding_count)
    );

    assign mem_op_ready   = !q_full;
    assign mem_resp_ready = !q_empty && (!result_valid_q || load_result_ready);
    assign resp_fire      = mem_resp_valid && mem_resp_ready;
    assign result_fire    = result_valid_q && load_result_ready;

    always_comb begin
        result_valid_d = result_valid_q;
        result_d       = result_q;
        if (resp_fire) begin
            result_valid_d = 1'b1;
            result_d       = gecko_get_load_operation(q_head, mem_resp_data);
        end else if (result_fire) begin
            result_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_valid_q <= 1'b0;
            result_q       <= '0;
        end else begin
            result_valid_q <= result_valid_d;
            result_q       <= result_d;
        end
    end

    assign load_result_valid = result_valid_q;
    assign load_result_data  = result_q;
    assign load_forward      = gecko_construct_forward(result_valid_q, result_q);

endmodule

// File: tb/tb_gecko_load_writeback.sv
// Bench for gecko_load_writeback: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_gecko_load_writeback;
  import gecko_load_writeback_pkg::*;

  localparam int DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 mem_op_valid = 1'b0;
  logic                 mem_op_ready;
  gecko_mem_operation_t mem_op_data = '0;
  logic                 mem_resp_valid = 1'b0;
  logic                 mem_resp_ready;
  logic [31:0]          mem_resp_data = '0;
  logic                 load_result_valid;
  logic                 load_result_ready = 1'b1;
  gecko_operation_t     load_result_data;
  gecko_forwarded_t     load_forward;
  logic [2:0]           outstanding_count;

  int errors = 0;
  int checks = 0;

  gecko_load_writeback #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .mem_op_valid      (mem_op_valid),
    .mem_op_ready      (mem_op_ready),
    .mem_op_data       (mem_op_data),
    .mem_resp_valid    (mem_resp_valid),
    .mem_resp_ready    (mem_resp_ready),
    .mem_resp_data     (mem_resp_data),
    .load_result_valid (load_result_valid),
    .load_result_ready (load_result_ready),
    .load_result_data  (load_result_data),
    .load_forward      (load_forward),
    .outstanding_count (outstanding_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // reference model: plain arithmetic on the raw word
  function automatic logic [31:0] model_value(input logic [2:0] op, input logic [1:0] off,
                                              input logic [31:0] w);
    int unsigned b;
    int unsigned h;
    b = (w / (32'd1 << (8 * off))) % 256;
    h = (off >= 2) ? (w / 65536) : (w % 65536);
    case (op)
      3'd0: return (b >= 128) ? (b - 256) : b;
      3'd1: return (h >= 32768) ? (h - 65536) : h;
      3'd4: return b;
      3'd5: return h;
      default: return w;
    endcase
  endfunction

  gecko_mem_operation_t m_q[$];
  logic                 m_valid = 1'b0;
  gecko_operation_t     m_out = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_valid = 1'b0;
    end else begin
      logic                 push;
      logic                 pop;
      gecko_mem_operation_t h;
      push = mem_op_valid && (m_q.size() < DEPTH);
      pop  = mem_resp_valid && (m_q.size() > 0) && (!m_valid || load_result_ready);
      if (pop) begin
        h = m_q.pop_front();
        m_out.value       = model_value(h.op, h.offset, mem_resp_data);
        m_out.addr        = h.addr;
        m_out.speculative = 1'b0;
        m_out.reg_status  = h.reg_status;
        m_out.jump_flag   = h.jump_flag;
        m_valid = 1'b1;
      end else if (m_valid && load_result_ready) begin
        m_valid = 1'b0;
      end
      if (push) m_q.push_back(mem_op_data);
    end
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    chk("op_ready", mem_op_ready, m_q.size() < DEPTH);
    chk("resp_ready", mem_resp_ready, (m_q.size() > 0) && (!m_valid || load_result_ready));
    chk("count", outstanding_count, m_q.size());
    chk("result_valid", load_result_valid, m_valid);
    chk("fwd_valid", load_forward.valid, m_valid);
    if (m_valid) begin
      chk("result_data", load_result_data, m_out);
      chk("fwd_data", {load_forward.value, load_forward.addr, load_forward.reg_status},
          {m_out.value, m_out.addr, m_out.reg_status});
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [4:0] addr, input logic [2:0] op, input logic [1:0] off);
    mem_op_data.addr       = addr;
    mem_op_data.reg_status = 4'(addr);
    mem_op_data.jump_flag  = addr[0];
    mem_op_data.op         = op;
    mem_op_data.offset     = off;
  endtask

  task automatic do_load(input string name, input logic [4:0] addr, input logic [2:0] op,
                         input logic [1:0] off, input logic [31:0] word,
                         input logic [31:0] exp_value);
    mem_op_valid = 1'b1;
    set_op(addr, op, off);
    cyc();
    mem_op_valid   = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = word;
    cyc();
    mem_resp_valid = 1'b0;
    chk({name, "_valid"}, load_result_valid, 1'b1);
    chk({name, "_value"}, load_result_data.value, exp_value);
    chk({name, "_addr"}, load_result_data.addr, addr);
    chk({name, "_spec"}, load_result_data.speculative, 1'b0);
    chk({name, "_fwd"}, load_forward.valid, 1'b1);
    cyc();
  endtask

  initial begin
    #12;
    // reset state
    chk("rst_valid", load_result_valid, 1'b0);
    chk("rst_data", load_result_data, 0);
    chk("rst_count", outstanding_count, 0);
    chk("rst_op_ready", mem_op_ready, 1'b1);
    chk("rst_resp_ready", mem_resp_ready, 1'b0);
    rst = 1'b1;
    cyc();

    // formatting
    do_load("lb", 5'd5, 3'd0, 2'd2, 32'h12803456, 32'hFFFFFF80);
    do_load("lhu", 5'd6, 3'd5, 2'd2, 32'hBEEF1234, 32'h0000BEEF);
    do_load("lh", 5'd7, 3'd1, 2'd2, 32'hBEEF1234, 32'hFFFFBEEF);
    do_load("lw", 5'd8, 3'd2, 2'd0, 32'hBEEF1234, 32'hBEEF1234);
    do_load("lbu", 5'd9, 3'd4, 2'd3, 32'h9A345678, 32'h0000009A);

    // fill to DEPTH, then drain in push order
    for (int i = 1; i <= 4; i++) begin
      mem_op_valid = 1'b1;
      set_op(5'(i), 3'd2, 2'd0);
      cyc();
    end
    mem_op_valid = 1'b0;
    chk("full_count", outstanding_count, 4);
    chk("full_op_ready", mem_op_ready, 1'b0);
    mem_resp_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      mem_resp_data = 32'h1000 + 32'(i);
      cyc();
      chk("drain_addr", load_result_data.addr, 5'(i));
      chk("drain_value", load_result_data.value, 32'h1000 + 32'(i));
      if (i == 1) begin
        chk("drain_count", outstanding_count, 3);
        chk("drain_op_ready", mem_op_ready, 1'b1);
      end
    end
    mem_resp_valid = 1'b0;
    cyc();

    // backpressure holds the result
    for (int i = 6; i <= 7; i++) begin
      mem_op_valid = 1'b1;
      set_op(5'(i), 3'd2, 2'd0);
      cyc();
    end
    mem_op_valid      = 1'b0;
    load_result_ready = 1'b0;
    mem_resp_valid    = 1'b1;
    mem_resp_data     = 32'hAAAA0006;
    cyc();
    mem_resp_data = 32'hAAAA0007;
    for (int k = 0; k < 2; k++) begin
      cyc();
      chk("bp_valid", load_result_valid, 1'b1);
      chk("bp_addr", load_result_data.addr, 5'd6);
      chk("bp_value", load_result_data.value, 32'hAAAA0006);
      chk("bp_resp_ready", mem_resp_ready, 1'b0);
    end
    load_result_ready = 1'b1;
    cyc();
    mem_resp_valid = 1'b0;
    chk("bp_next_addr", load_result_data.addr, 5'd7);
    chk("bp_next_valid", load_result_valid, 1'b1);
    cyc();
    chk("bp_done_valid", load_result_valid, 1'b0);

    // response with empty queue is ignored
    mem_resp_valid = 1'b1;
    #1;
    chk("empty_resp_ready", mem_resp_ready, 1'b0);
    cyc();
    chk("empty_valid", load_result_valid, 1'b0);
    chk("empty_count", outstanding_count, 0);
    mem_resp_valid = 1'b0;

    // asynchronous reset mid-operation
    for (int i = 1; i <= 4; i++) begin
      mem_op_valid = 1'b1;
      set_op(5'(i + 10), 3'd2, 2'd0);
      cyc();
    end
    mem_op_valid      = 1'b0;
    load_result_ready = 1'b0;
    mem_resp_valid    = 1'b1;
    cyc();
    mem_resp_valid = 1'b0;
    chk("pre_rst_count", outstanding_count, 3);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", load_result_valid, 1'b0);
    chk("arst_count", outstanding_count, 0);
    chk("arst_op_ready", mem_op_ready, 1'b1);
    load_result_ready = 1'b1;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    do_load("post_rst_lw", 5'd3, 3'd2, 2'd1, 32'hCAFEF00D, 32'hCAFEF00D);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      mem_op_valid      = ($urandom_range(0, 1) == 1);
      set_op(5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      mem_resp_valid    = ($urandom_range(0, 3) != 0);
      mem_resp_data     = $urandom;
      load_result_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    mem_op_valid   = 1'b0;
    mem_resp_valid = 1'b0;
    cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
